// File: rtl/calc_pkg.sv
// Shared calculator definitions: button indices, debounce FSM encoding, key priority.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package calc_pkg;

    localparam int BTN_IDX_W = 3;
    localparam int EV_W      = 8;   // padded event width addressable by a btn_idx_t
    localparam int N_PRIO    = 5;

    typedef logic [BTN_IDX_W-1:0] btn_idx_t;

    localparam btn_idx_t BTN_U = 3'd0;
    localparam btn_idx_t BTN_D = 3'd1;
    localparam btn_idx_t BTN_L = 3'd2;
    localparam btn_idx_t BTN_R = 3'd3;
    localparam btn_idx_t BTN_S = 3'd4;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b10,
        RELEASE_WAIT = 2'b11
    } btn_state_t;

    // Highest priority first; matches the precedence of the mode state machine.
    localparam logic [BTN_IDX_W*N_PRIO-1:0] PRIO_ORDER = {BTN_S, BTN_R, BTN_L, BTN_U, BTN_D};

    // Returns a one-hot grant for the highest-priority raised event (or zero).
    function automatic logic [EV_W-1:0] prio_grant(input logic [EV_W-1:0] ev);
        logic [BTN_IDX_W*N_PRIO-1:0] order;
        logic [EV_W-1:0]             grant;
        logic                        done;
        order = PRIO_ORDER;
        grant = '0;
        done  = 1'b0;
        for (int i = 0; i < N_PRIO; i++) begin
            if (!done && ev[order[BTN_IDX_W*N_PRIO-1 -: BTN_IDX_W]]) begin
                grant[order[BTN_IDX_W*N_PRIO-1 -: BTN_IDX_W]] = 1'b1;
                done = 1'b1;
            end
            order = order << BTN_IDX_W;
        end
        return grant;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button synchroniser, tick-based debouncer and hold-to-repeat generator.
// Latency: 2 clk sync, then DB_TICKS ticks to accept a level change; o_event is combinational on the tick edge.
// Backpressure: none; o_event is a one-clk pulse the consumer must take or lose.
module btn_debounce
    import calc_pkg::*;
#(
    parameter int DB_TICKS     = 8,
    parameter int REPEAT_DELAY = 333,
    parameter int REPEAT_RATE  = 66,
    parameter int CNT_W        = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_tick,
    input  logic i_btn,
    input  logic i_repeat_en,
    output logic o_held,
    output logic o_event
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DLY_LIMIT = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_LIM  = CNT_W'(REPEAT_RATE);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    btn_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_limit;
    logic             r_rep;       // 0: waiting out the initial delay, 1: in the repeat cadence
    logic             w_rep_nxt;
    logic             w_event;

    // Two-flop synchroniser on the raw pin, runs every clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // FSM state, shared counter and repeat-phase register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rep   <= w_rep_nxt;
        end
    end

    // Next-state and raw event; everything advances only on tick.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rep_nxt   = r_rep;
        w_event     = 1'b0;
        w_limit     = r_rep ? RATE_LIM : DLY_LIMIT;
        if (i_tick) begin
            case (r_state)
                RELEASED: begin
                    if (r_sync2) begin
                        w_state_nxt = PRESS_WAIT;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
                PRESS_WAIT: begin
                    if (!r_sync2) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_rep_nxt   = 1'b0;
                        w_event     = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!r_sync2) begin
                        w_state_nxt = RELEASE_WAIT;
                        w_cnt_nxt   = CNT_ONE;
                    end else if (i_repeat_en) begin
                        if ((r_cnt + 1'b1) == w_limit) begin
                            w_cnt_nxt = '0;
                            w_rep_nxt = 1'b1;
                            w_event   = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end else begin
                        // Repeat disabled: park so re-enabling starts from the full delay.
                        w_cnt_nxt = '0;
                        w_rep_nxt = 1'b0;
                    end
                end
                RELEASE_WAIT: begin
                    if (r_sync2) begin
                        // Release glitch: back to held, repeat timing restarts from the delay.
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        w_rep_nxt   = 1'b0;
                    end else if (r_cnt == DB_LAST) begin
                        w_state_nxt = RELEASED;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = RELEASED;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign o_held  = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
    assign o_event = w_event;

endmodule

// File: rtl/button_conditioner.sv
// Calculator button front end: per-button debounce/repeat plus fixed-priority key arbitration.
// Latency: 2 clk sync + DB_TICKS ticks to press; press/any_press registered, held for one tick period.
// Backpressure: none; events losing arbitration on a tick are dropped, not queued.
module button_conditioner
    import calc_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int DB_TICKS     = 8,
    parameter int REPEAT_DELAY = 333,
    parameter int REPEAT_RATE  = 66,
    parameter int CNT_W        = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press,
    output logic             any_press
);

    logic [N_BTN-1:0] w_held;
    logic [N_BTN-1:0] w_event;
    logic [EV_W-1:0]  w_ev_pad;
    logic [EV_W-1:0]  w_grant;
    logic [N_BTN-1:0] r_press;
    logic             r_any;

    for (genvar g = 0; g < N_BTN; g++) begin : g_btn
        btn_debounce #(
            .DB_TICKS     (DB_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE),
            .CNT_W        (CNT_W)
        ) u_debounce (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_tick      (tick),
            .i_btn       (btn_raw[g]),
            .i_repeat_en (repeat_en[g]),
            .o_held      (w_held[g]),
            .o_event     (w_event[g])
        );
    end

    // Pad the raw events so the priority helper can address them by button index.
    always_comb begin
        w_ev_pad               = '0;
        w_ev_pad[N_BTN-1:0]    = w_event;
    end

    assign w_grant = prio_grant(w_ev_pad);

    // Output registers update only on tick so each event lasts one full tick period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_press <= '0;
            r_any   <= 1'b0;
        end else if (tick) begin
            r_press <= w_grant[N_BTN-1:0];
            r_any   <= |w_grant;
        end
    end

    assign held      = w_held;
    assign press     = r_press;
    assign any_press = r_any;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with a run-length reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_button_conditioner;

    localparam int NB = 5;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RR = 3;
    localparam int TP = 10;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          tick      = 1'b0;
    logic [NB-1:0] btn_raw   = '0;
    logic [NB-1:0] repeat_en = '0;
    logic [NB-1:0] held;
    logic [NB-1:0] press;
    logic          any_press;

    int n_cmp = 0;
    int n_err = 0;

    button_conditioner #(
        .N_BTN(NB), .DB_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .CNT_W(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .btn_raw(btn_raw), .repeat_en(repeat_en),
        .held(held), .press(press), .any_press(any_press)
    );

    always #5 clk = ~clk;

    // one-clk tick every TP clocks, changed on negedges
    initial begin
        forever begin
            repeat (TP - 1) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    // Level flips after DB consecutive opposite samples; while held, repeat events
    // fall at RD ticks after the anchor and every RR ticks after that.
    logic [NB-1:0] m_d1 = '0, m_d2 = '0, m_ev = '0;
    logic [NB-1:0] exp_held = '0, exp_press = '0;
    logic          exp_any = 1'b0;
    logic          m_found;
    int            m_run [NB];
    int            m_anc [NB];
    int            m_tk  = 0;
    int            m_dd;
    int            prio  [NB] = '{4, 3, 2, 0, 1};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_d1 = '0; m_d2 = '0; exp_held = '0; exp_press = '0; exp_any = 1'b0; m_tk = 0;
            for (int b = 0; b < NB; b++) begin m_run[b] = 0; m_anc[b] = 0; end
        end else begin
            if (tick) begin
                m_tk++;
                m_ev = '0;
                for (int b = 0; b < NB; b++) begin
                    if (m_d2[b] == exp_held[b]) begin
                        if (m_d2[b] && m_run[b] != 0) m_anc[b] = m_tk;
                        m_run[b] = 0;
                        if (m_d2[b]) begin
                            if (!repeat_en[b]) m_anc[b] = m_tk;
                            else begin
                                m_dd = m_tk - m_anc[b];
                                if (m_dd >= RD && ((m_dd - RD) % RR) == 0) m_ev[b] = 1'b1;
                            end
                        end
                    end else begin
                        m_run[b]++;
                        if (m_run[b] == DB) begin
                            exp_held[b] = m_d2[b];
                            m_run[b] = 0;
                            if (m_d2[b]) begin m_ev[b] = 1'b1; m_anc[b] = m_tk; end
                        end
                    end
                end
                exp_press = '0;
                m_found = 1'b0;
                for (int i = 0; i < NB; i++) begin
                    if (!m_found && m_ev[prio[i]]) begin exp_press[prio[i]] = 1'b1; m_found = 1'b1; end
                end
                exp_any = m_found;
            end
            m_d2 = m_d1;
            m_d1 = btn_raw;
        end
    end

    // ---------------- scenarios ----------------
    task automatic wait_tick_edge();
        @(posedge clk);
        while (!tick) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_check(input int cycles);
        btn_raw = '0;
        repeat_en = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL idle_model t=%0t got %b/%b/%b want %b/%b/%b", $time, held, press, any_press, exp_held, exp_press, exp_any);
            end
        end
    endtask

    task automatic test_reset();
        int n_hi;
        n_hi = 0;
        rst_n = 1'b0;
        btn_raw = 5'b10000;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({held, press, any_press} !== '0) begin
            n_err++;
            $display("FAIL reset_state got %b/%b/%b want 0", held, press, any_press);
        end
        wait_tick_edge();
        rst_n = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL reset_model c=%0d got %b/%b/%b want %b/%b/%b", c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c == 10 || c == 20 || c == 30) begin
                n_cmp++;
                if (held !== 5'b0 || press !== 5'b0) begin
                    n_err++;
                    $display("FAIL reset_early_press tick=%0d got held=%b press=%b want 0", c / TP, held, press);
                end
            end
            if (c == 40) begin
                n_cmp++;
                if (press !== 5'b10000) begin
                    n_err++;
                    $display("FAIL reset_tick4_press got %b want 10000", press);
                end
            end
            if (press[4]) n_hi++;
        end
        n_cmp++;
        if (n_hi != 10) begin
            n_err++;
            $display("FAIL reset_press_width got %0d clk want 10", n_hi);
        end
    endtask

    task automatic test_bounce();
        int got[$];
        int s;
        repeat_en = '0;
        wait_tick_edge();
        btn_raw[0] = 1'b1;
        for (int c = 1; c <= 130; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL bounce_model c=%0d got %b/%b/%b want %b/%b/%b", c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c % TP == 0) begin
                if (press[0]) got.push_back(c / TP);
                s = c / TP;
                btn_raw[0] = (s >= 4) ? 1'b1 : ((s % 2) == 0);
            end
        end
        n_cmp++;
        if (got.size() != 1) begin
            n_err++;
            $display("FAIL bounce_event_count got %0d want 1", got.size());
        end else begin
            n_cmp++;
            if (got[0] != 8) begin
                n_err++;
                $display("FAIL bounce_event_tick got %0d want 8", got[0]);
            end
        end
    endtask

    task automatic test_repeat(input logic en);
        int got[$];
        int want[$];
        if (en) want = '{4, 14, 17, 20};
        else    want = '{4};
        repeat_en = '0;
        repeat_en[3] = en;
        wait_tick_edge();
        btn_raw[3] = 1'b1;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL repeat_model en=%0b c=%0d got %b/%b/%b want %b/%b/%b", en, c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c % TP == 0) begin
                if (press[3]) got.push_back(c / TP);
                if (c / TP == 20) btn_raw[3] = 1'b0;
            end
        end
        n_cmp++;
        if (got.size() != want.size()) begin
            n_err++;
            $display("FAIL repeat_count en=%0b got %0d want %0d", en, got.size(), want.size());
        end else begin
            foreach (want[i]) begin
                n_cmp++;
                if (got[i] != want[i]) begin
                    n_err++;
                    $display("FAIL repeat_tick en=%0b idx=%0d got %0d want %0d", en, i, got[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_simultaneous(input logic [NB-1:0] pat, input int win, input int lose);
        int n_win;
        int n_lose;
        n_win = 0;
        n_lose = 0;
        repeat_en = '0;
        wait_tick_edge();
        btn_raw = pat;
        for (int c = 1; c <= 160; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL simul_model c=%0d got %b/%b/%b want %b/%b/%b", c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c % TP == 0) begin
                if (press[win])  n_win++;
                if (press[lose]) n_lose++;
                if (c / TP == 8) btn_raw = '0;
            end
        end
        n_cmp++;
        if (n_win != 1 || n_lose != 0) begin
            n_err++;
            $display("FAIL simul_arbitration pat=%b got win=%0d lose=%0d want 1/0", pat, n_win, n_lose);
        end
    endtask

    task automatic test_release_glitch();
        int n_ev;
        int s;
        n_ev = 0;
        repeat_en = '0;
        wait_tick_edge();
        btn_raw[1] = 1'b1;
        for (int c = 1; c <= 260; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL glitch_model c=%0d got %b/%b/%b want %b/%b/%b", c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c % TP == 0) begin
                s = c / TP;
                if (press[1]) n_ev++;
                if (s >= 4 && s <= 21) begin
                    n_cmp++;
                    if (held[1] !== 1'b1) begin
                        n_err++;
                        $display("FAIL glitch_held tick=%0d got %b want 1", s, held[1]);
                    end
                end
                btn_raw[1] = (s < 8) || (s >= 10 && s < 18);
            end
        end
        n_cmp++;
        if (n_ev != 1) begin
            n_err++;
            $display("FAIL glitch_events got %0d want 1", n_ev);
        end
    endtask

    task automatic test_mid_reset();
        int got[$];
        int n_d;
        n_d = 0;
        repeat_en = '0;
        wait_tick_edge();
        btn_raw[1] = 1'b1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL midrst_model c=%0d got %b/%b/%b want %b/%b/%b", c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c == 60) btn_raw[0] = 1'b1;
            if (c == 85) begin
                rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({held, press, any_press} !== '0) begin
                    n_err++;
                    $display("FAIL midrst_immediate got %b/%b/%b want 0", held, press, any_press);
                end
            end
            if (c == 86) rst_n = 1'b1;
            if (c == 110) begin
                n_cmp++;
                if (held !== 5'b0) begin
                    n_err++;
                    $display("FAIL midrst_restart got held=%b want 0", held);
                end
            end
            if (c % TP == 0 && c > 86) begin
                if (press[0]) got.push_back(c / TP);
                if (press[1]) n_d++;
            end
        end
        n_cmp++;
        if (got.size() != 1 || n_d != 0) begin
            n_err++;
            $display("FAIL midrst_events got U=%0d D=%0d want 1/0", got.size(), n_d);
        end else begin
            n_cmp++;
            if (got[0] != 12) begin
                n_err++;
                $display("FAIL midrst_press_tick got %0d want 12", got[0]);
            end
        end
    endtask

    task automatic test_random();
        int thr [NB];
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({held, press, any_press} !== {exp_held, exp_press, exp_any}) begin
                n_err++;
                $display("FAIL random_model c=%0d got %b/%b/%b want %b/%b/%b", c, held, press, any_press, exp_held, exp_press, exp_any);
            end
            if (c % 400 == 0) begin
                repeat_en = NB'($urandom);
                for (int b = 0; b < NB; b++) begin
                    case ($urandom_range(0, 2))
                        0:       thr[b] = 8;
                        1:       thr[b] = 60;
                        default: thr[b] = 400;
                    endcase
                end
            end
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, thr[b] - 1) == 0) btn_raw[b] = ~btn_raw[b];
            end
        end
    endtask

    initial begin
        test_reset();
        idle_check(100);
        test_bounce();
        idle_check(100);
        test_repeat(1'b1);
        idle_check(60);
        test_repeat(1'b0);
        idle_check(60);
        test_simultaneous(5'b10100, 4, 2);
        idle_check(60);
        test_simultaneous(5'b00110, 2, 1);
        idle_check(60);
        test_release_glitch();
        idle_check(60);
        test_mid_reset();
        idle_check(100);
        test_random();
        idle_check(100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
